// File: rtl/sonar_ranger.sv
// sonar_ranger: HC-SR04 front end; periodic trigger, echo timing, cm conversion, strobed result.
// Ports: clk, rst (sync, active-high), echo_in (async raw echo), trig_out (sensor trigger),
//   dist_cm[6:0] (last result, held), dist_valid (1-clk result strobe), timeout (last result
//   was a timeout), busy (trigger start until dist_valid).
// Build option SONAR_MEDIAN3_EN: dist_cm becomes the median of the last three results.
module sonar_ranger #(
  parameter int PERIOD_CYCLES  = 6750000,
  parameter int TRIG_CYCLES    = 270,
  parameter int TIMEOUT_CYCLES = 810000,
  parameter int CM_MULT        = 671,
  parameter int CM_SHIFT       = 20,
  parameter int MAX_CM         = 99
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       echo_in,
  output logic       trig_out,
  output logic [6:0] dist_cm,
  output logic       dist_valid,
  output logic       timeout,
  output logic       busy
);
  localparam int PW = $clog2(PERIOD_CYCLES);
  localparam logic [19:0] TRIG_LAST = 20'(TRIG_CYCLES - 1);
  localparam logic [19:0] TMO = 20'(TIMEOUT_CYCLES);
  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, CALC, TOUT, FILT, DONE} state_t;
`ifdef SONAR_MEDIAN3_EN
  localparam state_t POST = FILT;
`else
  localparam state_t POST = DONE;
`endif
  state_t r_state, w_state;
  logic [19:0] r_cnt, w_cnt;
  logic [PW-1:0] r_per;
  logic r_echo_m, r_echo_s, r_echo_d, r_first, r_tout;
  logic [6:0] r_dist, w_res;
  logic [29:0] w_prod, w_cm;
  assign w_prod = {10'd0, r_cnt} * 30'(CM_MULT);
  assign w_cm = w_prod >> CM_SHIFT;
  assign w_res = (r_state == TOUT || w_cm > 30'(MAX_CM)) ? 7'(MAX_CM) : w_cm[6:0];
  // r_first holds off the post-reset ping by one clk so trig_out never rises during rst
  assign trig_out = r_state == TRIG && !r_first;
  assign busy = !r_first && r_state != IDLE && r_state != DONE;
  assign dist_valid = r_state == DONE;
  assign dist_cm = r_dist;
  assign timeout = r_tout;
`ifdef SONAR_MEDIAN3_EN
  logic [6:0] r_res, r_w0, r_w1, w_b, w_c, w_lo, w_hi, w_mc, w_med;
  logic r_to, r_have;
  assign w_b = r_have ? r_w0 : r_res;
  assign w_c = r_have ? r_w1 : r_res;
  assign w_lo = (r_res < w_b) ? r_res : w_b;
  assign w_hi = (r_res < w_b) ? w_b : r_res;
  assign w_mc = (w_hi < w_c) ? w_hi : w_c;
  assign w_med = (w_lo > w_mc) ? w_lo : w_mc;
`endif
  always_comb begin
    w_state = r_state;
    w_cnt = r_cnt;
    case (r_state)
      IDLE: if (r_per == '0) begin
        w_state = TRIG;
        w_cnt = '0;
      end
      TRIG: if (!r_first) begin
        w_state = (r_cnt == TRIG_LAST) ? WAIT_RISE : TRIG;
        w_cnt = (r_cnt == TRIG_LAST) ? '0 : r_cnt + 20'd1;
      end
      // an echo already high on entry has r_echo_d set, so only a fresh rise counts
      WAIT_RISE: if (r_echo_s && !r_echo_d) begin
        w_state = MEASURE;
        w_cnt = 20'd1;
      end else if (r_cnt == TMO) w_state = TOUT;
      else w_cnt = r_cnt + 20'd1;
      MEASURE: if (!r_echo_s) w_state = CALC;
      else if (r_cnt == TMO) w_state = TOUT;
      else w_cnt = r_cnt + 20'd1;
      CALC, TOUT: w_state = POST;
      FILT: w_state = DONE;
      DONE: begin
        w_state = IDLE;
        w_cnt = '0;
      end
      default: w_state = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= TRIG;
      r_cnt <= '0;
      r_per <= '0;
      r_first <= 1'b1;
      {r_echo_m, r_echo_s, r_echo_d} <= '0;
      r_dist <= '0;
      r_tout <= 1'b0;
`ifdef SONAR_MEDIAN3_EN
      {r_res, r_w0, r_w1, r_to, r_have} <= '0;
`endif
    end else begin
      r_state <= w_state;
      r_cnt <= w_cnt;
      r_per <= (r_per == PW'(PERIOD_CYCLES - 1)) ? '0 : r_per + PW'(1);
      r_first <= 1'b0;
      {r_echo_m, r_echo_s, r_echo_d} <= {echo_in, r_echo_m, r_echo_s};
`ifdef SONAR_MEDIAN3_EN
      if (r_state == CALC || r_state == TOUT) begin
        r_res <= w_res;
        r_to <= r_state == TOUT;
      end
      // the first result after reset fills all three window slots
      if (r_state == FILT) begin
        r_dist <= w_med;
        r_tout <= r_to;
        r_w0 <= r_res;
        r_w1 <= w_b;
        r_have <= 1'b1;
      end
`else
      if (r_state == CALC || r_state == TOUT) begin
        r_dist <= w_res;
        r_tout <= r_state == TOUT;
      end
`endif
    end
  end
endmodule

// File: tb/tb_sonar_ranger.sv
// tb_sonar_ranger: directed checks of sonar_ranger with shortened timing parameters.
module tb_sonar_ranger;
  localparam int PERIOD = 500, TRIG = 10, TMO = 200;
`ifdef SONAR_MEDIAN3_EN
  localparam bit MED = 1'b1;
`else
  localparam bit MED = 1'b0;
`endif
  localparam int LAT = MED ? 5 : 4;
  logic clk = 1'b0, rst = 1'b1, echo_in = 1'b0;
  logic trig_out, dist_valid, timeout, busy;
  logic [6:0] dist_cm;
  int n_chk = 0, n_fail = 0, cyc = 0, t_rise, n, early;
  sonar_ranger #(.PERIOD_CYCLES(PERIOD), .TRIG_CYCLES(TRIG), .TIMEOUT_CYCLES(TMO),
                 .CM_MULT(671), .CM_SHIFT(10), .MAX_CM(99)) dut (
    .clk(clk), .rst(rst), .echo_in(echo_in), .trig_out(trig_out), .dist_cm(dist_cm),
    .dist_valid(dist_valid), .timeout(timeout), .busy(busy));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic wait_trig(input logic lvl, input string tag);
    int k = 0;
    while (trig_out !== lvl && k < 1000) begin
      tick();
      k++;
    end
    chk(tag, {31'd0, trig_out}, {31'd0, lvl});
  endtask
  // hi = echo high cycles, 0 = no new echo rise (timeout expected)
  task automatic do_ping(input int hi, input int exp_cm, input logic exp_to, input string tag);
    int t0, k;
    wait_trig(1'b1, {tag, "_rise"});
    chk({tag, "_busy"}, {31'd0, busy}, 1);
    wait_trig(1'b0, {tag, "_fall"});
    t0 = cyc;
    if (hi > 0) begin
      repeat (3) tick();
      echo_in = 1'b1;
      repeat (hi) tick();
      echo_in = 1'b0;
      t0 = cyc;
    end
    k = 0;
    while (dist_valid !== 1'b1 && k < 2000) begin
      tick();
      k++;
    end
    chk({tag, "_lat"}, cyc - t0, hi > 0 ? LAT : TMO + 2 + int'(MED));
    chk({tag, "_cm"}, {25'd0, dist_cm}, exp_cm);
    chk({tag, "_tout"}, {31'd0, timeout}, {31'd0, exp_to});
    chk({tag, "_busy0"}, {31'd0, busy}, 0);
    tick();
    chk({tag, "_strobe"}, {31'd0, dist_valid}, 0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (5) tick();
    chk("rst_trig", {31'd0, trig_out}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_valid", {31'd0, dist_valid}, 0);
    chk("rst_cm", {25'd0, dist_cm}, 0);
    chk("rst_tout", {31'd0, timeout}, 0);
    rst = 1'b0;
    tick();
    chk("first_trig", {31'd0, trig_out}, 1);
    t_rise = cyc;
    n = 0;
    while (trig_out && n < 1000) begin
      n++;
      tick();
    end
    chk("trig_width", n, TRIG);
    repeat (3) tick();
    echo_in = 1'b1;
    repeat (46) tick();
    echo_in = 1'b0;
    early = 0;
    repeat (LAT - 1) begin
      tick();
      if (dist_valid) early++;
    end
    chk("p1_early_valid", early, 0);
    chk("p1_cm_held", {25'd0, dist_cm}, 0);
    tick();
    chk("p1_valid", {31'd0, dist_valid}, 1);
    chk("p1_cm", {25'd0, dist_cm}, 30);
    chk("p1_tout", {31'd0, timeout}, 0);
    chk("p1_busy", {31'd0, busy}, 0);
    tick();
    chk("p1_strobe", {31'd0, dist_valid}, 0);
    chk("p1_hold", {25'd0, dist_cm}, 30);
    wait_trig(1'b1, "p2_rise0");
    chk("period", cyc - t_rise, PERIOD);
    do_ping(180, MED ? 30 : 99, 1'b0, "sat");
    do_ping(0, 99, 1'b1, "no_echo");
    echo_in = 1'b1;
    do_ping(0, 99, 1'b1, "echo_stuck");
    echo_in = 1'b0;
    wait_trig(1'b1, "r_rise");
    wait_trig(1'b0, "r_fall");
    repeat (3) tick();
    echo_in = 1'b1;
    repeat (20) tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_trig", {31'd0, trig_out}, 0);
    chk("mid_rst_busy", {31'd0, busy}, 0);
    chk("mid_rst_valid", {31'd0, dist_valid}, 0);
    chk("mid_rst_cm", {25'd0, dist_cm}, 0);
    chk("mid_rst_tout", {31'd0, timeout}, 0);
    echo_in = 1'b0;
    tick();
    chk("mid_rst_valid2", {31'd0, dist_valid}, 0);
    rst = 1'b0;
    tick();
    chk("post_rst_trig", {31'd0, trig_out}, 1);
    do_ping(31, 20, 1'b0, "post_rst");
    do_ping(16, MED ? 20 : 10, 1'b0, "short");
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    do_ping(16, 10, 1'b0, "m10");
    do_ping(77, MED ? 10 : 50, 1'b0, "m50");
    do_ping(31, 20, 1'b0, "m20");
    do_ping(0, MED ? 50 : 99, 1'b1, "mto");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
